// File: rtl/scan_pkg.sv
// Shared constants for the threshold scan sequencer: state codes, register
// offsets and CTRL/STATUS bit positions.
package scan_pkg;

    // Sequencer states
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StWaitDac = 3'd2;
    localparam logic [2:0] StSettle  = 3'd3;
    localparam logic [2:0] StStart   = 3'd4;
    localparam logic [2:0] StArm     = 3'd5;
    localparam logic [2:0] StRun     = 3'd6;
    localparam logic [2:0] StOut     = 3'd7;

    // Register offsets from the block base address
    localparam logic [7:0] RegCtrl    = 8'd0;
    localparam logic [7:0] RegStatus  = 8'd1;
    localparam logic [7:0] RegDacLo   = 8'd2;
    localparam logic [7:0] RegDacHi   = 8'd3;
    localparam logic [7:0] RegDacStep = 8'd4;
    localparam logic [7:0] RegNSteps  = 8'd5;
    localparam logic [7:0] RegGate    = 8'd6;
    localparam logic [7:0] RegCurStep = 8'd7;

    // CTRL and STATUS bit positions
    localparam int unsigned CtrlGoBit     = 0;
    localparam int unsigned CtrlAbortBit  = 1;
    localparam int unsigned StatusBusyBit = 0;
    localparam int unsigned StatusDoneBit = 1;
    localparam int unsigned StatusSatBit  = 2;

endpackage

// File: rtl/scan_regs.sv
// Host register file for the scan sequencer: bus decode, config storage,
// registered readback and self-clearing GO/ABORT strobes.
module scan_regs
    import scan_pkg::*;
#(
    parameter int unsigned DAC_W     = 12,  // supported range 9..16
    parameter logic [7:0]  BASE_ADDR = 8'h40
) (
    input  logic             clk,
    input  logic             res,
    input  logic [7:0]       addr,
    input  logic [7:0]       data_in,
    input  logic             we,
    output logic [7:0]       data_out,
    input  logic             busy,
    input  logic             done,
    input  logic             sat,
    input  logic [7:0]       cur_step,
    output logic             go,
    output logic             abort,
    output logic [DAC_W-1:0] dac_start,
    output logic [7:0]       dac_step,
    output logic [7:0]       n_steps,
    output logic [7:0]       gate_sec
);

    logic [7:0] off;
    logic [7:0] rd_val;

    // Offsets wrap, so anything below BASE_ADDR lands far above 7 and decodes as unmapped.
    assign off = addr - BASE_ADDR;

    // GO/ABORT exist only for the cycle of the write, so they clear themselves.
    assign go    = we && (off == RegCtrl) && data_in[CtrlGoBit];
    assign abort = we && (off == RegCtrl) && data_in[CtrlAbortBit];

    // Config register writes
    always_ff @(posedge clk) begin
        if (res) begin
            dac_start <= '0;
            dac_step  <= '0;
            n_steps   <= '0;
            gate_sec  <= '0;
        end else if (we) begin
            case (off)
                RegDacLo:   dac_start[7:0]       <= data_in;
                RegDacHi:   dac_start[DAC_W-1:8] <= data_in[DAC_W-9:0];
                RegDacStep: dac_step             <= data_in;
                RegNSteps:  n_steps              <= data_in;
                RegGate:    gate_sec             <= data_in;
                default: ;
            endcase
        end
    end

    // Readback mux
    always_comb begin
        rd_val = '0;
        case (off)
            RegStatus: begin
                rd_val[StatusBusyBit] = busy;
                rd_val[StatusDoneBit] = done;
                rd_val[StatusSatBit]  = sat;
            end
            RegDacLo:   rd_val = dac_start[7:0];
            RegDacHi:   rd_val = {{(16-DAC_W){1'b0}}, dac_start[DAC_W-1:8]};
            RegDacStep: rd_val = dac_step;
            RegNSteps:  rd_val = n_steps;
            RegGate:    rd_val = gate_sec;
            RegCurStep: rd_val = cur_step;
            default:    rd_val = '0;
        endcase
    end

    // Registered read data, one cycle behind addr
    always_ff @(posedge clk) begin
        if (res) begin
            data_out <= '0;
        end else begin
            data_out <= rd_val;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Threshold scan sequencer: steps the DAC threshold, runs the pulse counter
// once per step and streams one result record per step.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned DAC_W         = 12,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter logic [7:0]  BASE_ADDR     = 8'h40
) (
    input  logic             clk,
    input  logic             res,
    input  logic [7:0]       addr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    input  logic             we,
    output logic [DAC_W-1:0] dac_value,
    output logic             dac_load,
    input  logic             dac_busy,
    output logic [7:0]       cnt_gate,
    output logic             cnt_start,
    input  logic             cnt_stop,
    input  logic [31:0]      cnt_data,
    input  logic [31:0]      cnt_time,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_step,
    output logic [DAC_W-1:0] res_dac,
    output logic [31:0]      res_data,
    output logic [31:0]      res_time,
    output logic             busy,
    output logic             done
);

    logic [2:0]       state_q;
    logic [7:0]       idx_q;
    logic [7:0]       n_q;
    logic [7:0]       step_q;
    logic [DAC_W-1:0] start_q;
    logic [31:0]      settle_q;
    logic             wait_first_q;
    logic             sat_q;

    logic             go;
    logic             abort;
    logic [DAC_W-1:0] cfg_dac_start;
    logic [7:0]       cfg_dac_step;
    logic [7:0]       cfg_n_steps;
    logic [7:0]       cfg_gate_sec;

    logic [15:0]      prod;
    logic [DAC_W+7:0] dac_sum;
    logic             dac_ovf;
    logic [7:0]       idx_next;

    scan_regs #(
        .DAC_W    (DAC_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_regs (
        .clk      (clk),
        .res      (res),
        .addr     (addr),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .sat      (sat_q),
        .cur_step (idx_q),
        .go       (go),
        .abort    (abort),
        .dac_start(cfg_dac_start),
        .dac_step (cfg_dac_step),
        .n_steps  (cfg_n_steps),
        .gate_sec (cfg_gate_sec)
    );

    // Threshold for the current step, wide enough to detect overflow past full scale
    assign prod     = idx_q * step_q;
    assign dac_sum  = {8'd0, start_q} + {{(DAC_W-8){1'b0}}, prod};
    assign dac_ovf  = |dac_sum[DAC_W+7:DAC_W];
    assign idx_next = idx_q + 8'd1;
    assign busy     = (state_q != StIdle);

    // Scan FSM, datapath and result stage
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            n_q          <= '0;
            step_q       <= '0;
            start_q      <= '0;
            settle_q     <= '0;
            wait_first_q <= 1'b0;
            sat_q        <= 1'b0;
            dac_value    <= '0;
            dac_load     <= 1'b0;
            cnt_gate     <= '0;
            cnt_start    <= 1'b0;
            res_valid    <= 1'b0;
            res_step     <= '0;
            res_dac      <= '0;
            res_data     <= '0;
            res_time     <= '0;
            done         <= 1'b0;
        end else begin
            dac_load  <= 1'b0;
            cnt_start <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                state_q   <= StIdle;
                res_valid <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (go) begin
                            // Config is snapshotted here so host writes mid-scan stay pending.
                            start_q  <= cfg_dac_start;
                            step_q   <= cfg_dac_step;
                            n_q      <= cfg_n_steps;
                            cnt_gate <= cfg_gate_sec;
                            if (cfg_n_steps == 8'd0) begin
                                done <= 1'b1;
                            end else begin
                                idx_q   <= '0;
                                done    <= 1'b0;
                                sat_q   <= 1'b0;
                                state_q <= StLoad;
                            end
                        end
                    end
                    StLoad: begin
                        if (dac_ovf) begin
                            dac_value <= '1;
                            sat_q     <= 1'b1;
                        end else begin
                            dac_value <= dac_sum[DAC_W-1:0];
                        end
                        dac_load     <= 1'b1;
                        wait_first_q <= 1'b1;
                        state_q      <= StWaitDac;
                    end
                    StWaitDac: begin
                        // Busy from the DAC driver cannot rise before it has seen dac_load.
                        if (wait_first_q) begin
                            wait_first_q <= 1'b0;
                        end else if (!dac_busy) begin
                            settle_q <= SETTLE_CYCLES - 1;
                            state_q  <= StSettle;
                        end
                    end
                    StSettle: begin
                        if (settle_q == 32'd0) begin
                            state_q <= StStart;
                        end else begin
                            settle_q <= settle_q - 32'd1;
                        end
                    end
                    StStart: begin
                        cnt_start <= 1'b1;
                        state_q   <= StArm;
                    end
                    StArm: begin
                        if (!cnt_stop) begin
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (cnt_stop) begin
                            res_data  <= cnt_data;
                            res_time  <= cnt_time;
                            res_step  <= idx_q;
                            res_dac   <= dac_value;
                            res_valid <= 1'b1;
                            state_q   <= StOut;
                        end
                    end
                    StOut: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            idx_q     <= idx_next;
                            if (idx_next == n_q) begin
                                done    <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StLoad;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer with DAC/counter models and a record sink.
module tb_scan_sequencer;

    localparam int unsigned DAC_W  = 12;
    localparam int unsigned SETTLE = 16;
    localparam logic [7:0]  BASE   = 8'h40;

    logic             clk;
    logic             res;
    logic [7:0]       addr;
    logic [7:0]       data_in;
    logic [7:0]       data_out;
    logic             we;
    logic [DAC_W-1:0] dac_value;
    logic             dac_load;
    logic             dac_busy;
    logic [7:0]       cnt_gate;
    logic             cnt_start;
    logic             cnt_stop;
    logic [31:0]      cnt_data;
    logic [31:0]      cnt_time;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_step;
    logic [DAC_W-1:0] res_dac;
    logic [31:0]      res_data;
    logic [31:0]      res_time;
    logic             busy;
    logic             done;

    scan_sequencer #(
        .DAC_W        (DAC_W),
        .SETTLE_CYCLES(SETTLE),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk      (clk),
        .res      (res),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .we       (we),
        .dac_value(dac_value),
        .dac_load (dac_load),
        .dac_busy (dac_busy),
        .cnt_gate (cnt_gate),
        .cnt_start(cnt_start),
        .cnt_stop (cnt_stop),
        .cnt_data (cnt_data),
        .cnt_time (cnt_time),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_step (res_step),
        .res_dac  (res_dac),
        .res_data (res_data),
        .res_time (res_time),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  step;
        logic [11:0] dac;
        logic [31:0] data;
        logic [31:0] tm;
    } rec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp;
    } reg_vec_t;

    typedef struct {
        int start;
        int step;
        int n;
        int gate;
        int last_dac;
        int sat;
    } scan_vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t got_q[$];
    int   load_cnt;
    int   start_cnt;
    int   ready_mode;  // 0: always ready, 1: random, 2: held low

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // DAC driver model: busy for 1..5 cycles after each load
    int dac_bc;
    always @(posedge clk) begin
        if (res) begin
            dac_busy <= 1'b0;
            dac_bc   <= 0;
        end else if (dac_load) begin
            dac_busy <= 1'b1;
            dac_bc   <= $urandom_range(0, 4);
        end else if (dac_busy) begin
            if (dac_bc == 0) dac_busy <= 1'b0;
            else dac_bc <= dac_bc - 1;
        end
    end

    // Pulse counter model: k-th run since GO reports 5*(k+1) pulses
    int cnt_k;
    int cnt_rem;
    always @(posedge clk) begin
        if (res) begin
            cnt_stop <= 1'b1;
            cnt_data <= '0;
            cnt_time <= '0;
            cnt_k    <= 0;
            cnt_rem  <= 0;
        end else begin
            if (we && addr == BASE && data_in[0] && !busy) cnt_k <= 0;
            if (cnt_start) begin
                cnt_stop <= 1'b0;
                cnt_rem  <= int'(cnt_gate) * 3 + 1;
            end else if (!cnt_stop) begin
                if (cnt_rem == 0) begin
                    cnt_stop <= 1'b1;
                    cnt_data <= 32'(5 * (cnt_k + 1));
                    cnt_time <= 32'(50_000_000) * 32'(cnt_gate);
                    cnt_k    <= cnt_k + 1;
                end else begin
                    cnt_rem <= cnt_rem - 1;
                end
            end
        end
    end

    // Record sink and pulse counters
    always @(posedge clk) begin
        if (res) begin
            load_cnt  <= 0;
            start_cnt <= 0;
        end else begin
            if (dac_load) load_cnt <= load_cnt + 1;
            if (cnt_start) start_cnt <= start_cnt + 1;
            if (res_valid && res_ready) begin
                got_q.push_back('{step: res_step, dac: res_dac, data: res_data, tm: res_time});
            end
        end
    end

    always @(negedge clk) begin
        case (ready_mode)
            0:       res_ready <= 1'b1;
            1:       res_ready <= 1'($urandom_range(0, 1));
            default: res_ready <= 1'b0;
        endcase
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr    = a;
        data_in = d;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic bus_read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        @(posedge clk);
        #1;
        chk(name, 32'(data_out), 32'(exp));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic configure(input int start, input int step, input int n, input int gate);
        bus_write(BASE + 8'd2, 8'(start));
        bus_write(BASE + 8'd3, 8'(start >> 8));
        bus_write(BASE + 8'd4, 8'(step));
        bus_write(BASE + 8'd5, 8'(n));
        bus_write(BASE + 8'd6, 8'(gate));
    endtask

    // Runs a full scan and checks every record against the arithmetic model
    task automatic run_scan(input int start, input int step, input int n, input int gate,
                            output int base);
        int exp_sat;
        int l0;
        int got_n;
        exp_sat = 0;
        configure(start, step, n, gate);
        base = got_q.size();
        l0   = load_cnt;
        bus_write(BASE, 8'h01);
        wait_idle(n * 300 + 100);
        got_n = got_q.size() - base;
        chk("rec_count", 32'(got_n), 32'(n));
        chk("load_count", 32'(load_cnt - l0), 32'(n));
        for (int i = 0; i < n; i++) begin
            int v;
            v = start + i * step;
            if (v > 4095) begin
                v = 4095;
                exp_sat = 1;
            end
            if (i < got_n) begin
                chk("rec_step", 32'(got_q[base+i].step), 32'(i));
                chk("rec_dac", 32'(got_q[base+i].dac), 32'(v));
                chk("rec_data", got_q[base+i].data, 32'(5 * (i + 1)));
                chk("rec_time", got_q[base+i].tm, 32'(50_000_000) * 32'(gate));
            end
        end
        chk("done_after_scan", 32'(done), 32'd1);
        bus_read_chk("status_after_scan", BASE + 8'd1, 8'(exp_sat * 4 + 2));
        bus_read_chk("cur_step_after_scan", BASE + 8'd7, 8'(n));
    endtask

    reg_vec_t  rv[10];
    scan_vec_t sv[2];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int l0;
        int s0;
        int r0;
        int ok;
        logic [7:0]  snap_step;
        logic [11:0] snap_dac;
        logic [31:0] snap_data;

        res        = 1'b1;
        addr       = '0;
        data_in    = '0;
        we         = 1'b0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        res = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_dac", 32'({dac_load, dac_value}), 0);
        chk("rst_cnt", 32'({cnt_start, cnt_gate}), 0);
        for (int i = 0; i < 8; i++) bus_read_chk("rst_reg", BASE + 8'(i), 8'h00);

        // Register readback table
        rv[0] = '{a: BASE + 8'd2, wd: 8'h5A, exp: 8'h5A};
        rv[1] = '{a: BASE + 8'd3, wd: 8'hF3, exp: 8'h03};
        rv[2] = '{a: BASE + 8'd4, wd: 8'hC7, exp: 8'hC7};
        rv[3] = '{a: BASE + 8'd5, wd: 8'h09, exp: 8'h09};
        rv[4] = '{a: BASE + 8'd6, wd: 8'h81, exp: 8'h81};
        rv[5] = '{a: BASE + 8'd0, wd: 8'h00, exp: 8'h00};
        rv[6] = '{a: BASE + 8'd1, wd: 8'hFF, exp: 8'h00};
        rv[7] = '{a: BASE + 8'd7, wd: 8'hFF, exp: 8'h00};
        rv[8] = '{a: BASE + 8'd8, wd: 8'hAA, exp: 8'h00};
        rv[9] = '{a: BASE - 8'd1, wd: 8'h55, exp: 8'h00};
        for (int i = 0; i < 10; i++) bus_write(rv[i].a, rv[i].wd);
        for (int i = 0; i < 10; i++) bus_read_chk("readback", rv[i].a, rv[i].exp);
        pulse_reset();

        // Directed scans: basic and saturation
        sv[0] = '{start: 100,  step: 10, n: 3, gate: 1, last_dac: 120,  sat: 0};
        sv[1] = '{start: 4090, step: 4,  n: 3, gate: 1, last_dac: 4095, sat: 1};
        for (int i = 0; i < 2; i++) begin
            run_scan(sv[i].start, sv[i].step, sv[i].n, sv[i].gate, base);
            if (got_q.size() >= base + sv[i].n)
                chk("table_last_dac", 32'(got_q[base+sv[i].n-1].dac), 32'(sv[i].last_dac));
            bus_read_chk("table_status", BASE + 8'd1, 8'(sv[i].sat * 4 + 2));
            chk("table_busy", 32'(busy), 0);
        end

        // Backpressure: hold res_ready low for 20 cycles in OUT
        configure(500, 3, 2, 0);
        ready_mode = 2;
        base = got_q.size();
        bus_write(BASE, 8'h01);
        for (int i = 0; i < 300 && !res_valid; i++) @(negedge clk);
        chk("bp_valid_reached", 32'(res_valid), 1);
        snap_step = res_step;
        snap_dac  = res_dac;
        snap_data = res_data;
        l0 = load_cnt;
        s0 = start_cnt;
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!res_valid || res_step != snap_step || res_dac != snap_dac ||
                res_data != snap_data) ok = 0;
        end
        chk("bp_hold_stable", 32'(ok), 1);
        chk("bp_no_load", 32'(load_cnt - l0), 0);
        chk("bp_no_start", 32'(start_cnt - s0), 0);
        chk("bp_first_dac", 32'(snap_dac), 500);
        ready_mode = 0;
        wait_idle(600);
        chk("bp_rec_count", 32'(got_q.size() - base), 2);
        if (got_q.size() >= base + 2) begin
            chk("bp_rec1_dac", 32'(got_q[base+1].dac), 503);
            chk("bp_rec1_data", got_q[base+1].data, 10);
        end

        // Randomized scans against the model
        ready_mode = 1;
        for (int t = 0; t < 6; t++) begin
            run_scan($urandom_range(3000, 4095), $urandom_range(0, 255), $urandom_range(1, 5),
                     $urandom_range(0, 2), base);
        end
        ready_mode = 0;

        // Abort during RUN of step 1
        configure(200, 1, 3, 5);
        base = got_q.size();
        s0 = start_cnt;
        bus_write(BASE, 8'h01);
        for (int i = 0; i < 600 && start_cnt < s0 + 2; i++) @(negedge clk);
        chk("abort_reach_step1", 32'(start_cnt - s0), 2);
        repeat (4) @(negedge clk);
        bus_write(BASE, 8'h02);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rec_count", 32'(got_q.size() - base), 1);
        if (got_q.size() > base) chk("abort_rec_step", 32'(got_q[base].step), 0);
        l0 = load_cnt;
        s0 = start_cnt;
        repeat (30) @(negedge clk);
        chk("abort_no_load", 32'(load_cnt - l0), 0);
        chk("abort_no_start", 32'(start_cnt - s0), 0);
        bus_read_chk("abort_cur_step", BASE + 8'd7, 8'd1);

        // N_STEPS = 0: done without any activity
        configure(200, 1, 0, 5);
        l0 = load_cnt;
        r0 = got_q.size();
        bus_write(BASE, 8'h01);
        chk("n0_done", 32'(done), 1);
        chk("n0_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        chk("n0_no_load", 32'(load_cnt - l0), 0);
        chk("n0_no_rec", 32'(got_q.size() - r0), 0);

        // Restart after abort begins at step 0
        run_scan(200, 1, 1, 5, base);

        // Reset asserted mid-SETTLE
        configure(77, 1, 2, 1);
        l0 = load_cnt;
        bus_write(BASE, 8'h01);
        for (int i = 0; i < 20 && load_cnt == l0; i++) @(negedge clk);
        for (int i = 0; i < 10 && !dac_busy; i++) @(negedge clk);
        for (int i = 0; i < 10 && dac_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("settle_busy", 32'(busy), 1);
        pulse_reset();
        chk("rs_busy_done", 32'({busy, done}), 0);
        chk("rs_dac", 32'({dac_load, dac_value}), 0);
        chk("rs_cnt", 32'({cnt_start, cnt_gate}), 0);
        chk("rs_res_hdr", 32'({res_valid, res_step, res_dac}), 0);
        chk("rs_res_data", res_data, 0);
        chk("rs_res_time", res_time, 0);
        chk("rs_data_out", 32'(data_out), 0);
        for (int i = 0; i < 8; i++) bus_read_chk("rs_reg", BASE + 8'(i), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
